clk_meas: RTL and testbench

Synthesizable clock/waveform monitor that sits directly downstream of the programmable clock generator and consumes the clock it produces. It samples the generated clock `sig_in` against the system clock `clk` and measures four values, all in `clk` cycles:
- phase: the offset from a `start` pulse to the first rising edge;
- high time;
- low time;
- period.

It reports them with a one-cycle valid strobe, so benches and on-chip self-test can check the generator's frequency, duty-cycle and phase settings numerically instead of by waveform inspection.

---
 rtl/clk_meas_pkg.sv | 15 +
 rtl/sync_edge_det.sv | 36 +++
 rtl/clk_meas.sv | 137 +++++++++++++
 tb/tb_clk_meas.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_meas_pkg.sv
// Shared types and defaults for the clock/waveform monitor.
package clk_meas_pkg;

    localparam int unsigned CNT_W_DEFAULT   = 16;
    localparam int unsigned SYNC_STAGES_MIN = 2;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_RISE,
        HIGH,
        LOW,
        DONE
    } meas_state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous input followed by a registered-delay
// rise/fall detector on the synchronized level.
module sync_edge_det
    import clk_meas_pkg::*;
#(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise,
    output logic fall
);

    // Fewer than two stages gives no metastability margin, so clamp.
    localparam int unsigned N = (STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : STAGES;

    logic [N-1:0] chain;
    logic         sig_s;
    logic         sig_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= '0;
            sig_d <= 1'b0;
        end else begin
            chain <= {chain[N-2:0], din};
            sig_d <= sig_s;
        end
    end

    assign sig_s = chain[N-1];
    assign rise  = sig_s & ~sig_d;
    assign fall  = ~sig_s & sig_d;

endmodule

// File: rtl/clk_meas.sv
// Measures phase-from-start, high time, low time and period of an asynchronous clock,
// all in system clock cycles, and reports them with a one-cycle valid strobe.
module clk_meas
    import clk_meas_pkg::*;
#(
    parameter int unsigned CNT_W       = CNT_W_DEFAULT,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    input  logic             start,
    output logic             busy,
    output logic             meas_valid,
    output logic             ovf,
    output logic [CNT_W-1:0] phase_cnt,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] low_cnt,
    output logic [CNT_W:0]   period_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    meas_state_t      state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] phase_cap;
    logic [CNT_W-1:0] high_cap;
    logic             rise;
    logic             fall;
    logic             cnt_max;

    sync_edge_det #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (sig_in),
        .rise (rise),
        .fall (fall)
    );

    assign cnt_max = &cnt;

    // Intermediate captures stay internal so the published results only change at DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            phase_cap  <= '0;
            high_cap   <= '0;
            busy       <= 1'b0;
            meas_valid <= 1'b0;
            ovf        <= 1'b0;
            phase_cnt  <= '0;
            high_cnt   <= '0;
            low_cnt    <= '0;
            period_cnt <= '0;
        end else begin
            meas_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state <= WAIT_RISE;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                WAIT_RISE: begin
                    if (rise) begin
                        phase_cap <= cnt;
                        cnt       <= CNT_ONE;
                        state     <= HIGH;
                    end else if (cnt_max) begin
                        phase_cnt  <= '0;
                        high_cnt   <= '0;
                        low_cnt    <= '0;
                        period_cnt <= '0;
                        ovf        <= 1'b1;
                        busy       <= 1'b0;
                        meas_valid <= 1'b1;
                        state      <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HIGH: begin
                    if (fall) begin
                        high_cap <= cnt;
                        cnt      <= CNT_ONE;
                        state    <= LOW;
                    end else if (cnt_max) begin
                        phase_cnt  <= phase_cap;
                        high_cnt   <= '0;
                        low_cnt    <= '0;
                        period_cnt <= '0;
                        ovf        <= 1'b1;
                        busy       <= 1'b0;
                        meas_valid <= 1'b1;
                        state      <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                LOW: begin
                    if (rise) begin
                        phase_cnt  <= phase_cap;
                        high_cnt   <= high_cap;
                        low_cnt    <= cnt;
                        period_cnt <= {1'b0, high_cap} + {1'b0, cnt};
                        ovf        <= 1'b0;
                        busy       <= 1'b0;
                        meas_valid <= 1'b1;
                        state      <= DONE;
                    end else if (cnt_max) begin
                        phase_cnt  <= phase_cap;
                        high_cnt   <= high_cap;
                        low_cnt    <= '0;
                        period_cnt <= '0;
                        ovf        <= 1'b1;
                        busy       <= 1'b0;
                        meas_valid <= 1'b1;
                        state      <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clk_meas.sv
// Self-checking bench for clk_meas: expected results are queued when stimulus is
// driven and popped when the monitor reports a measurement.
module tb_clk_meas;

    localparam int SYNC = 2;

    logic clk     = 1'b0;
    logic rst     = 1'b1;
    logic start   = 1'b0;
    logic sig_drv = 1'b0;
    logic gen_en  = 1'b0;
    logic gen_sig = 1'b0;
    logic sig_in;

    logic        busy, meas_valid, ovf;
    logic [15:0] phase_cnt, high_cnt, low_cnt;
    logic [16:0] period_cnt;

    logic        busy4, valid4, ovf4;
    logic [3:0]  phase4, high4, low4;
    logic [4:0]  period4;

    typedef struct {
        int ph;
        int hi;
        int lo;
        int per;
        bit ovf;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    assign sig_in = gen_en ? gen_sig : sig_drv;

    always #5 clk = ~clk;

    clk_meas #(
        .CNT_W       (16),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sig_in     (sig_in),
        .start      (start),
        .busy       (busy),
        .meas_valid (meas_valid),
        .ovf        (ovf),
        .phase_cnt  (phase_cnt),
        .high_cnt   (high_cnt),
        .low_cnt    (low_cnt),
        .period_cnt (period_cnt)
    );

    clk_meas #(
        .CNT_W       (4),
        .SYNC_STAGES (SYNC)
    ) dut4 (
        .clk        (clk),
        .rst        (rst),
        .sig_in     (sig_in),
        .start      (start),
        .busy       (busy4),
        .meas_valid (valid4),
        .ovf        (ovf4),
        .phase_cnt  (phase4),
        .high_cnt   (high4),
        .low_cnt    (low4),
        .period_cnt (period4)
    );

    // 25 MHz, 40 % duty source; edges land off the clk grid.
    initial begin : gen
        wait (gen_en);
        #8;
        forever begin
            gen_sig = 1'b1;
            #16;
            gen_sig = 1'b0;
            #24;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog");
    end

    // One start at cycle 0 (plus optional extra), then a wave: high for cyc<pre,
    // high for [k,k+h), low for [k+h,k+h+l), high from k+h+l on. Returns the edge
    // index after which meas_valid was seen, or -1.
    task automatic drive_wave(input int k, input int h, input int l, input int pre,
                              input int extra, output int vcyc);
        vcyc = -1;
        for (int cyc = 0; cyc < k + h + l + 40; cyc++) begin
            start   = (cyc == 0) || (cyc == extra);
            sig_drv = (cyc < pre) || (cyc >= k && cyc < k + h) || (cyc >= k + h + l);
            @(negedge clk);
            if (meas_valid === 1'b1) begin
                vcyc = cyc;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sig_drv = ~sig_drv;
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || meas_valid !== 1'b0 || ovf !== 1'b0) begin
                errors++;
                $display("FAIL reset_ctrl: busy=%b valid=%b ovf=%b, required 0 0 0",
                         busy, meas_valid, ovf);
            end
            checks++;
            if (phase_cnt !== 16'd0 || high_cnt !== 16'd0 || low_cnt !== 16'd0 ||
                period_cnt !== 17'd0) begin
                errors++;
                $display("FAIL reset_counts: phase=%0d high=%0d low=%0d period=%0d, required 0",
                         phase_cnt, high_cnt, low_cnt, period_cnt);
            end
        end
        checks++;
        if (busy4 !== 1'b0 || valid4 !== 1'b0 || ovf4 !== 1'b0 || period4 !== 5'd0) begin
            errors++;
            $display("FAIL reset_small: busy=%b valid=%b ovf=%b period=%0d, required 0",
                     busy4, valid4, ovf4, period4);
        end
        rst     = 1'b0;
        sig_drv = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_wave();
        int tk[4] = '{3, 0, 5, 2};
        int th[4] = '{4, 1, 7, 3};
        int tl[4] = '{6, 1, 2, 9};
        int tp[4] = '{0, 0, 2, 0};
        for (int i = 0; i < 4; i++) begin
            exp_t e;
            int   vcyc;
            // With pre>0 the input is already high so its rise coincides with start.
            sig_drv = (tp[i] > 0);
            repeat (2) @(negedge clk);
            exp_q.push_back('{tk[i] + SYNC - 1, th[i], tl[i], th[i] + tl[i], 1'b0});
            drive_wave(tk[i], th[i], tl[i], tp[i], -1, vcyc);
            e = exp_q.pop_front();
            checks++;
            if (vcyc != tk[i] + th[i] + tl[i] + SYNC) begin
                errors++;
                $display("FAIL wave%0d_latency: valid after edge %0d, required %0d",
                         i, vcyc, tk[i] + th[i] + tl[i] + SYNC);
            end
            checks++;
            if (phase_cnt !== 16'(e.ph)) begin
                errors++;
                $display("FAIL wave%0d_phase: got %0d required %0d", i, phase_cnt, e.ph);
            end
            checks++;
            if (high_cnt !== 16'(e.hi) || low_cnt !== 16'(e.lo)) begin
                errors++;
                $display("FAIL wave%0d_hilo: got %0d/%0d required %0d/%0d",
                         i, high_cnt, low_cnt, e.hi, e.lo);
            end
            checks++;
            if (period_cnt !== 17'(e.per) || ovf !== e.ovf || busy !== 1'b0) begin
                errors++;
                $display("FAIL wave%0d_period: period=%0d ovf=%b busy=%b required %0d %b 0",
                         i, period_cnt, ovf, busy, e.per, e.ovf);
            end
            sig_drv = 1'b1;
            @(negedge clk);
            checks++;
            if (meas_valid !== 1'b0 || phase_cnt !== 16'(e.ph) || period_cnt !== 17'(e.per)) begin
                errors++;
                $display("FAIL wave%0d_hold: valid=%b phase=%0d period=%0d required 0 %0d %0d",
                         i, meas_valid, phase_cnt, period_cnt, e.ph, e.per);
            end
            sig_drv = 1'b0;
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic test_start_ignored();
        exp_t e;
        int   vcyc;
        int   late_busy;
        exp_q.push_back('{3, 6, 5, 11, 1'b0});
        drive_wave(2, 6, 5, 0, 6, vcyc);
        e = exp_q.pop_front();
        checks++;
        if (vcyc != 15 || phase_cnt !== 16'(e.ph) || high_cnt !== 16'(e.hi) ||
            low_cnt !== 16'(e.lo) || period_cnt !== 17'(e.per)) begin
            errors++;
            $display("FAIL start_in_high: edge=%0d ph=%0d hi=%0d lo=%0d per=%0d required 15 %0d %0d %0d %0d",
                     vcyc, phase_cnt, high_cnt, low_cnt, period_cnt, e.ph, e.hi, e.lo, e.per);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (meas_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL start_in_done: valid=%b busy=%b required 0 0", meas_valid, busy);
        end
        late_busy = 0;
        repeat (4) begin
            @(negedge clk);
            if (busy !== 1'b0 || meas_valid !== 1'b0) late_busy++;
        end
        checks++;
        if (late_busy != 0) begin
            errors++;
            $display("FAIL start_in_done_idle: %0d busy/valid cycles, required 0", late_busy);
        end
        sig_drv = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int   vcyc;
        int   stray;
        for (int cyc = 0; cyc <= 9; cyc++) begin
            start   = (cyc == 0);
            sig_drv = (cyc >= 2 && cyc < 5) || (cyc >= 13);
            rst     = (cyc == 9);
            @(negedge clk);
        end
        rst     = 1'b0;
        sig_drv = 1'b0;
        checks++;
        if (busy !== 1'b0 || meas_valid !== 1'b0 || ovf !== 1'b0 || phase_cnt !== 16'd0 ||
            high_cnt !== 16'd0 || low_cnt !== 16'd0 || period_cnt !== 17'd0) begin
            errors++;
            $display("FAIL reset_in_low: busy=%b valid=%b ovf=%b ph=%0d hi=%0d lo=%0d per=%0d required all 0",
                     busy, meas_valid, ovf, phase_cnt, high_cnt, low_cnt, period_cnt);
        end
        stray = 0;
        repeat (20) begin
            @(negedge clk);
            if (meas_valid !== 1'b0 || busy !== 1'b0) stray++;
        end
        checks++;
        if (stray != 0) begin
            errors++;
            $display("FAIL reset_in_low_quiet: %0d busy/valid cycles, required 0", stray);
        end
        exp_q.push_back('{2, 2, 3, 5, 1'b0});
        drive_wave(1, 2, 3, 0, -1, vcyc);
        e = exp_q.pop_front();
        checks++;
        if (vcyc != 8 || phase_cnt !== 16'(e.ph) || high_cnt !== 16'(e.hi) ||
            low_cnt !== 16'(e.lo) || period_cnt !== 17'(e.per) || ovf !== e.ovf) begin
            errors++;
            $display("FAIL reset_then_measure: edge=%0d ph=%0d hi=%0d lo=%0d per=%0d ovf=%b required 8 %0d %0d %0d %0d %b",
                     vcyc, phase_cnt, high_cnt, low_cnt, period_cnt, ovf,
                     e.ph, e.hi, e.lo, e.per, e.ovf);
        end
        sig_drv = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_generator();
        int sum;
        int got;
        sum    = 0;
        gen_en = 1'b1;
        repeat (3) @(negedge clk);
        for (int run = 0; run < 20; run++) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            got = 0;
            for (int w = 0; w < 60; w++) begin
                @(negedge clk);
                if (meas_valid === 1'b1) begin
                    got = 1;
                    break;
                end
            end
            checks++;
            if (got == 0) begin
                errors++;
                $display("FAIL gen%0d_timeout: no meas_valid within 60 cycles, required one", run);
            end
            checks++;
            if (!(high_cnt === 16'd1 || high_cnt === 16'd2) ||
                !(low_cnt === 16'd2 || low_cnt === 16'd3)) begin
                errors++;
                $display("FAIL gen%0d_duty: high=%0d low=%0d required {1,2} {2,3}",
                         run, high_cnt, low_cnt);
            end
            checks++;
            if (period_cnt < 17'd3 || period_cnt > 17'd5 || ovf !== 1'b0) begin
                errors++;
                $display("FAIL gen%0d_period: period=%0d ovf=%b required 3..5 and 0",
                         run, period_cnt, ovf);
            end
            sum += int'(period_cnt);
            @(negedge clk);
        end
        checks++;
        if (sum != 4 * 20) begin
            errors++;
            $display("FAIL gen_mean: period sum=%0d over 20 runs, required 80", sum);
        end
        gen_en  = 1'b0;
        sig_drv = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    // Small-counter instance: timeout in WAIT_RISE (stuck low) and in HIGH (stuck high).
    task automatic test_timeout();
        int kk[2] = '{-1, 1};
        int ev[2] = '{16, 18};
        int ep[2] = '{0, 2};
        for (int i = 0; i < 2; i++) begin
            exp_t e;
            int   vcyc;
            vcyc = -1;
            exp_q.push_back('{ep[i], 0, 0, 0, 1'b1});
            for (int cyc = 0; cyc < 40; cyc++) begin
                start   = (cyc == 0);
                sig_drv = (kk[i] >= 0) && (cyc >= kk[i]);
                @(negedge clk);
                if (valid4 === 1'b1) begin
                    vcyc = cyc;
                    break;
                end
            end
            start = 1'b0;
            e = exp_q.pop_front();
            checks++;
            if (vcyc != ev[i]) begin
                errors++;
                $display("FAIL timeout%0d_latency: valid after edge %0d, required %0d",
                         i, vcyc, ev[i]);
            end
            checks++;
            if (ovf4 !== e.ovf || busy4 !== 1'b0) begin
                errors++;
                $display("FAIL timeout%0d_flag: ovf=%b busy=%b required 1 0", i, ovf4, busy4);
            end
            checks++;
            if (phase4 !== 4'(e.ph) || high4 !== 4'(e.hi) || low4 !== 4'(e.lo) ||
                period4 !== 5'(e.per)) begin
                errors++;
                $display("FAIL timeout%0d_counts: ph=%0d hi=%0d lo=%0d per=%0d required %0d 0 0 0",
                         i, phase4, high4, low4, period4, e.ph);
            end
            rst     = 1'b1;
            sig_drv = 1'b0;
            @(negedge clk);
            rst = 1'b0;
            repeat (3) @(negedge clk);
        end
    endtask

    initial begin : main
        test_reset();
        test_wave();
        test_start_ignored();
        test_reset_mid();
        test_generator();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
